// File: rtl/ssl_pkg.sv
// ssl_pkg: shared state type, default frame geometry and width helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ssl_pkg;

   localparam int NCH_DEF   = 3;
   localparam int NDATA_DEF = 128;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      COMPUTE = 2'd2,
      OUTPUT  = 2'd3
   } state_t;

   // Width of an index over 0..n-1, never less than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a count over 0..n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ssl_corr_mc_if.sv
// ssl_corr_mc_if: control, sample and result signals of the correlator.
// Latency: n/a (wiring only).
// Backpressure: out_valid/out_ready handshake on the result side.
// master = sample/control source + result consumer, slave = ssl_corr_mc.
//   en, smp_en, din[NCH:0] (bit0 = reference), out_ready  : master -> slave
//   out_valid, lag, score, busy, lag_ok                    : slave -> master
interface ssl_corr_mc_if #(
   parameter int NCH   = ssl_pkg::NCH_DEF,
   parameter int NDATA = ssl_pkg::NDATA_DEF,
   parameter int NLAG  = ssl_pkg::NDATA_DEF
);
   localparam int LAGW = ssl_pkg::idx_w(NLAG);
   localparam int SCW  = ssl_pkg::cnt_w(NDATA);

   logic                en;
   logic                smp_en;
   logic [NCH:0]        din;
   logic                out_ready;
   logic                out_valid;
   logic [NCH*LAGW-1:0] lag;
   logic [NCH*SCW-1:0]  score;
   logic                busy;
   logic [NCH-1:0]      lag_ok;

   modport master (
      output en, smp_en, din, out_ready,
      input  out_valid, lag, score, busy, lag_ok
   );

   modport slave (
      input  en, smp_en, din, out_ready,
      output out_valid, lag, score, busy, lag_ok
   );

endinterface

// File: rtl/ssl_popcnt.sv
// ssl_popcnt: counts positions where a and b agree (XNOR + balanced adder tree).
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: a, b (NDATA bits each) in; cnt (SCW bits, 0..NDATA) out.
module ssl_popcnt
   import ssl_pkg::*;
#(
   parameter int NDATA = NDATA_DEF,
   parameter int SCW   = cnt_w(NDATA)
) (
   input  logic [NDATA-1:0] a,
   input  logic [NDATA-1:0] b,
   output logic [SCW-1:0]   cnt
);

   // Leaves are padded to a power of two; padding leaves contribute zero.
   localparam int LVLS   = $clog2(NDATA);
   localparam int LEAVES = 1 << LVLS;

   genvar l, i;
   generate
      for (l = 0; l <= LVLS; l++) begin : g_lvl
         localparam int N = LEAVES >> l;
         logic [SCW-1:0] s [N];
         for (i = 0; i < N; i++) begin : g_node
            if (l == 0) begin : g_leaf
               if (i < NDATA) begin : g_bit
                  assign s[i] = SCW'(a[i] ~^ b[i]);
               end else begin : g_pad
                  assign s[i] = '0;
               end
            end else begin : g_add
               // Partial sums never exceed NDATA, so SCW bits never overflow.
               assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
            end
         end
      end
   endgenerate

   assign cnt = g_lvl[LVLS].s[0];

endmodule

// File: rtl/ssl_corr_mc.sv
// ssl_corr_mc: captures NDATA strobed samples of a reference plus NCH mics, then finds per-channel best circular lag.
// Latency: result valid NCH*NLAG+1 cycles after the strobe that completes the frame.
// Backpressure: result held stable while out_valid && !out_ready; strobes outside CAPTURE are dropped.
// Ports: clk, rst (async, active-low); io (slave modport): en, smp_en, din[NCH:0] (bit0 = reference),
//        out_ready in; out_valid, lag[NCH*LAGW], score[NCH*SCW], busy, lag_ok[NCH] out.
// Build option: define SSL_THRESH_EN to drive lag_ok[c] = (score_c >= THRESH); otherwise lag_ok is all-ones.
module ssl_corr_mc
   import ssl_pkg::*;
#(
   parameter int NCH    = NCH_DEF,
   parameter int NDATA  = NDATA_DEF,
   parameter int NLAG   = NDATA_DEF,
   parameter int LAGW   = idx_w(NLAG),
   parameter int SCW    = cnt_w(NDATA),
   parameter int THRESH = NDATA / 2
) (
   input  logic         clk,
   input  logic         rst,
   ssl_corr_mc_if.slave io
);

   localparam int SCNTW = idx_w(NDATA);
   localparam int CHW   = idx_w(NCH);
   localparam int RW    = $clog2(2 * NDATA);

   localparam logic [SCNTW-1:0] SCNT_LAST = SCNTW'(NDATA - 1);
   localparam logic [LAGW-1:0]  K_LAST    = LAGW'(NLAG - 1);
   localparam logic [CHW-1:0]   CH_LAST   = CHW'(NCH - 1);

   state_t              state, state_n;
   logic [SCNTW-1:0]    scnt;
   logic [LAGW-1:0]     k;
   logic [CHW-1:0]      ch;
   logic [LAGW-1:0]     best_lag;
   logic [SCW-1:0]      best_score;
   logic [NCH*LAGW-1:0] lag_r;
   logic [NCH*SCW-1:0]  score_r;

   // Frame buffer: no reset, contents are only read after a full capture.
   logic [NDATA-1:0]    ref_buf;
   logic [NDATA-1:0]    sig_buf [NCH];

   logic [NDATA-1:0]    sig_sel;
   logic [2*NDATA-1:0]  sig_dbl;
   logic [NDATA-1:0]    sig_rot;
   logic [SCW-1:0]      corr;
   logic                take;
   logic [LAGW-1:0]     cand_lag;
   logic [SCW-1:0]      cand_score;

`ifdef SSL_THRESH_EN
   logic [NCH-1:0]      ok_r;
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (io.en) state_n = CAPTURE;
         CAPTURE: if (io.smp_en && scnt == SCNT_LAST) state_n = COMPUTE;
         COMPUTE: if (ch == CH_LAST && k == K_LAST) state_n = OUTPUT;
         OUTPUT:  if (io.out_ready) state_n = io.en ? CAPTURE : IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign io.out_valid = (state == OUTPUT);
   assign io.busy      = (state != IDLE);

   // ---------------- capture ----------------
   always_ff @(posedge clk) begin
      if (state == CAPTURE && io.smp_en) begin
         ref_buf[scnt] <= io.din[0];
         for (int c = 0; c < NCH; c++) sig_buf[c][scnt] <= io.din[c+1];
      end
   end

   // ---------------- correlation ----------------
   always_comb begin
      sig_sel = '0;
      for (int c = 0; c < NCH; c++) begin
         if (ch == CHW'(c)) sig_sel = sig_buf[c];
      end
   end

   // Bit j of the doubled word at offset k is sig[(j+k) mod NDATA], since k < NDATA.
   assign sig_dbl = {sig_sel, sig_sel};
   assign sig_rot = sig_dbl[RW'(k) +: NDATA];

   ssl_popcnt #(
      .NDATA (NDATA),
      .SCW   (SCW)
   ) u_popcnt (
      .a   (ref_buf),
      .b   (sig_rot),
      .cnt (corr)
   );

   // Lag 0 always seeds the search; strict > keeps the lowest lag on ties.
   assign take       = (k == '0) || (corr > best_score);
   assign cand_lag   = take ? k    : best_lag;
   assign cand_score = take ? corr : best_score;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scnt       <= '0;
         k          <= '0;
         ch         <= '0;
         best_lag   <= '0;
         best_score <= '0;
         lag_r      <= '0;
         score_r    <= '0;
`ifdef SSL_THRESH_EN
         ok_r       <= '0;
`endif
      end else begin
         case (state)
            IDLE: scnt <= '0;
            CAPTURE: begin
               if (io.smp_en) begin
                  if (scnt == SCNT_LAST) begin
                     scnt       <= '0;
                     k          <= '0;
                     ch         <= '0;
                     best_lag   <= '0;
                     best_score <= '0;
                  end else begin
                     scnt <= scnt + 1'b1;
                  end
               end
            end
            COMPUTE: begin
               best_lag   <= cand_lag;
               best_score <= cand_score;
               if (k == K_LAST) begin
                  k  <= '0;
                  ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                  for (int c = 0; c < NCH; c++) begin
                     if (ch == CHW'(c)) begin
                        lag_r[c*LAGW +: LAGW]  <= cand_lag;
                        score_r[c*SCW +: SCW]  <= cand_score;
`ifdef SSL_THRESH_EN
                        ok_r[c]                <= (cand_score >= SCW'(THRESH));
`endif
                     end
                  end
               end else begin
                  k <= k + 1'b1;
               end
            end
            OUTPUT: if (io.out_ready) scnt <= '0;
            default: ;
         endcase
      end
   end

   assign io.lag   = lag_r;
   assign io.score = score_r;
`ifdef SSL_THRESH_EN
   assign io.lag_ok = ok_r;
`else
   assign io.lag_ok = '1;
`endif

   // Elaboration-time guard against inconsistent overrides.
   if (NLAG < 1 || NLAG > NDATA || LAGW < idx_w(NLAG) || SCW < cnt_w(NDATA) || THRESH > NDATA)
   begin : g_param_check
      $error("ssl_corr_mc: inconsistent parameters");
   end

endmodule

// File: tb/tb_ssl_corr_mc.sv
// tb_ssl_corr_mc: directed + randomized frames against a brute-force lag-search model.
// Latency: n/a (testbench).
// Backpressure: exercises out_ready held low during OUTPUT.
module tb_ssl_corr_mc;
   import ssl_pkg::*;

   localparam int NCH    = 3;
   localparam int NDATA  = 128;
   localparam int NLAG   = 128;
   localparam int LAGW   = idx_w(NLAG);
   localparam int SCW    = cnt_w(NDATA);
   localparam int NCH1   = 2;
   localparam int NDATA1 = 16;
   localparam int LAGW1  = idx_w(1);
   localparam int SCW1   = cnt_w(NDATA1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   int unsigned frame[$];
   int          exp_lag [4];
   int          exp_sc  [4];
   bit          exp_ok  [4];

   always #5 clk = ~clk;

   ssl_corr_mc_if #(.NCH(NCH),  .NDATA(NDATA),  .NLAG(NLAG)) io  ();
   ssl_corr_mc_if #(.NCH(NCH1), .NDATA(NDATA1), .NLAG(1))    io1 ();

   ssl_corr_mc #(.NCH(NCH), .NDATA(NDATA), .NLAG(NLAG)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   ssl_corr_mc #(.NCH(NCH1), .NDATA(NDATA1), .NLAG(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .io  (io1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // mode 0: all zero, 1: impulses, 2: alternating ref/ch0, 3: ch1 = ref delayed by 37, else random
   task automatic build(input int mode, input int ndata, input int nch);
      int unsigned w, t;
      frame.delete();
      for (int j = 0; j < ndata; j++) begin
         w = $urandom;
         case (mode)
            0: w = 0;
            1: begin
               w = 0;
               w[0] = (j == 10);
               w[1] = (j == 15);
               w[2] = (j == 10);
               w[3] = (j == 2);
            end
            2: begin
               w[0] = j[0];
               w[1] = j[0];
            end
            default: ;
         endcase
         w = w & ((32'd1 << (nch + 1)) - 32'd1);
         frame.push_back(w);
      end
      if (mode == 3) begin
         for (int j = 0; j < ndata; j++) begin
            w = frame[j];
            t = frame[(j - 37 + ndata) % ndata];
            w[2] = t[0];
            frame[j] = w;
         end
      end
   endtask

   // Exhaustive search straight from the definition: first lag reaching the maximum agreement count.
   task automatic model(input int nch, input int nlag);
      int nd, s;
      int unsigned a, b;
      nd = frame.size();
      for (int c = 0; c < nch; c++) begin
         exp_sc[c]  = -1;
         exp_lag[c] = 0;
         for (int k = 0; k < nlag; k++) begin
            s = 0;
            for (int j = 0; j < nd; j++) begin
               a = frame[j];
               b = frame[(j + k) % nd];
               if (a[0] == b[c+1]) s++;
            end
            if (s > exp_sc[c]) begin
               exp_sc[c]  = s;
               exp_lag[c] = k;
            end
         end
`ifdef SSL_THRESH_EN
         exp_ok[c] = (exp_sc[c] >= nd / 2);
`else
         exp_ok[c] = 1'b1;
`endif
      end
   endtask

   task automatic start_frame(input string tag);
      io.en = 1'b1;
      @(posedge clk); #1;
      io.en = 1'b0;
      chk({tag, "_busy_start"}, 32'(io.busy), 32'd1);
   endtask

   task automatic capture(input bit gaps);
      for (int j = 0; j < frame.size(); j++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               io.smp_en = 1'b0;
               io.din    = (NCH+1)'($urandom);
               @(posedge clk); #1;
            end
         end
         io.din    = (NCH+1)'(frame[j]);
         io.smp_en = 1'b1;
         @(posedge clk); #1;
      end
      io.smp_en = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_valid"}, 32'(io.out_valid), 32'd1);
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("%s_lag%0d", tag, c),   32'(io.lag[c*LAGW +: LAGW]),  exp_lag[c]);
         chk($sformatf("%s_score%0d", tag, c), 32'(io.score[c*SCW +: SCW]),  exp_sc[c]);
         chk($sformatf("%s_ok%0d", tag, c),    32'(io.lag_ok[c]),            32'(exp_ok[c]));
      end
   endtask

   // Called just after the final strobe edge; the strobe cycle itself counts as one.
   task automatic finish_frame(input string tag);
      int cyc;
      cyc = 0;
      while (io.out_valid !== 1'b1 && cyc < 2 * NCH * NLAG + 16) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_latency"}, cyc + 1, NCH * NLAG + 1);
      model(NCH, NLAG);
      check_outputs(tag);
   endtask

   task automatic accept(input bit en_next, input string tag);
      io.out_ready = 1'b1;
      io.en        = en_next;
      @(posedge clk); #1;
      io.out_ready = 1'b0;
      io.en        = 1'b0;
      chk({tag, "_valid_drop"}, 32'(io.out_valid), 32'd0);
      chk({tag, "_busy_after"}, 32'(io.busy), 32'(en_next));
   endtask

   initial begin
      int cyc;
      io.en = 1'b0;  io.smp_en = 1'b0;  io.din = '0;  io.out_ready = 1'b0;
      io1.en = 1'b0; io1.smp_en = 1'b0; io1.din = '0; io1.out_ready = 1'b0;

      // reset state
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(io.out_valid), 32'd0);
      chk("rst_busy",  32'(io.busy), 32'd0);
      chk("rst_lag",   32'(io.lag), 32'd0);
      chk("rst_score", 32'(io.score), 32'd0);
`ifdef SSL_THRESH_EN
      chk("rst_ok",    32'(io.lag_ok), 32'd0);
`else
      chk("rst_ok",    32'(io.lag_ok), 32'd7);
`endif
      rst = 1'b1;
      @(posedge clk); #1;
      chk("idle_busy", 32'(io.busy), 32'd0);

      // all-zero frame, consumer always ready
      io.out_ready = 1'b1;
      build(0, NDATA, NCH);
      start_frame("zero");
      capture(1'b0);
      finish_frame("zero");
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("zero_lag_const%0d", c),   32'(io.lag[c*LAGW +: LAGW]), 32'd0);
         chk($sformatf("zero_score_const%0d", c), 32'(io.score[c*SCW +: SCW]), 32'd128);
      end
      accept(1'b0, "zero");

      // impulses: ref@10, ch0@15, ch1@10, ch2@2
      build(1, NDATA, NCH);
      start_frame("imp");
      capture(1'b1);
      finish_frame("imp");
      chk("imp_lag0_const", 32'(io.lag[0*LAGW +: LAGW]), 32'd5);
      chk("imp_lag1_const", 32'(io.lag[1*LAGW +: LAGW]), 32'd0);
      chk("imp_lag2_const", 32'(io.lag[2*LAGW +: LAGW]), 32'd120);
      accept(1'b0, "imp");

      // alternating ref and ch0: ties at every even lag resolve to lag 0
      build(2, NDATA, NCH);
      start_frame("alt");
      capture(1'b1);
      finish_frame("alt");
      chk("alt_lag0_const",   32'(io.lag[0*LAGW +: LAGW]), 32'd0);
      chk("alt_score0_const", 32'(io.score[0*SCW +: SCW]), 32'd128);
      accept(1'b0, "alt");

      // ch1 is ref delayed by 37, others random
      build(3, NDATA, NCH);
      start_frame("shift");
      capture(1'b1);
      finish_frame("shift");
      chk("shift_lag1_const", 32'(io.lag[1*LAGW +: LAGW]), 32'd37);
      accept(1'b0, "shift");

      // random frame, then 20 cycles of backpressure with strobes that must be dropped
      build(4, NDATA, NCH);
      start_frame("bp");
      capture(1'b1);
      finish_frame("bp");
      for (int i = 0; i < 20; i++) begin
         io.smp_en = ~io.smp_en;
         io.din    = (NCH+1)'($urandom);
         io.en     = 1'b1;
         @(posedge clk); #1;
         check_outputs($sformatf("bp_hold%0d", i));
      end
      io.smp_en = 1'b0;
      accept(1'b1, "bp");

      // back-to-back frame started by acceptance with en high
      build(4, NDATA, NCH);
      capture(1'b1);
      finish_frame("b2b");
      accept(1'b0, "b2b");

      // reset in the middle of COMPUTE
      build(4, NDATA, NCH);
      start_frame("mid");
      capture(1'b0);
      repeat (49) begin
         @(posedge clk); #1;
      end
      chk("mid_busy_before", 32'(io.busy), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(io.out_valid), 32'd0);
      chk("mid_rst_busy",  32'(io.busy), 32'd0);
      chk("mid_rst_lag",   32'(io.lag), 32'd0);
      chk("mid_rst_score", 32'(io.score), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // fresh frame after reset
      build(4, NDATA, NCH);
      start_frame("post");
      capture(1'b1);
      finish_frame("post");
      accept(1'b0, "post");

      // single-lag instance: lag is always 0
      build(4, NDATA1, NCH1);
      io1.en = 1'b1;
      @(posedge clk); #1;
      io1.en = 1'b0;
      for (int j = 0; j < NDATA1; j++) begin
         io1.din    = (NCH1+1)'(frame[j]);
         io1.smp_en = 1'b1;
         @(posedge clk); #1;
      end
      io1.smp_en = 1'b0;
      cyc = 0;
      while (io1.out_valid !== 1'b1 && cyc < 32) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("n1_latency", cyc + 1, NCH1 + 1);
      model(NCH1, 1);
      for (int c = 0; c < NCH1; c++) begin
         chk($sformatf("n1_lag%0d", c),   32'(io1.lag[c*LAGW1 +: LAGW1]), 32'd0);
         chk($sformatf("n1_score%0d", c), 32'(io1.score[c*SCW1 +: SCW1]), exp_sc[c]);
      end
      io1.out_ready = 1'b1;
      @(posedge clk); #1;
      io1.out_ready = 1'b0;
      chk("n1_valid_drop", 32'(io1.out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
